// File: rtl/data_mem_lsu.sv
`default_nettype none
// data_mem_lsu -- word-organised data memory behind a RISC-V style load/store unit with fixed access latency.
// Optional build macro: DMEM_MISALIGN_CHECK_EN rejects misaligned H/HU/W accesses. Rev 1.0
module data_mem_lsu #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];

  logic              accept, access, live;
  logic              a_we;
  logic [2:0]        a_size;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [IDX_W-1:0]  idx;
  logic              oor, bad_size, misalign, err;
  logic [31:0]       word, byte_sh, half_sh, load_data;
  logic [31:0]       lane_mask, lane_data, store_word;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait the access happens on the accept edge, so the live inputs are used
  // instead of the (not yet loaded) capture registers.
  assign access  = (state != RESP) && (state_nxt == RESP);
  assign live    = (state == IDLE);
  assign a_we    = live ? req_we    : we_q;
  assign a_size  = live ? req_size  : size_q;
  assign a_addr  = live ? req_addr  : addr_q;
  assign a_wdata = live ? req_wdata : wdata_q;

  assign idx = a_addr[IDX_W+1:2];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign oor = |a_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_norange
      assign oor = 1'b0;
    end
  endgenerate

  assign bad_size = (a_size == 3'b011) || (a_size[2:1] == 2'b11) || (a_we && a_size[2]);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((a_size[1:0] == 2'b01) && a_addr[0]) ||
                    ((a_size == 3'b010) && (a_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err  = oor || bad_size || misalign;
  assign word = mem[idx];

  // Lane selection ignores the sub-lane address bits, which forces natural alignment.
  assign byte_sh = word >> {a_addr[1:0], 3'b000};
  assign half_sh = word >> {a_addr[1], 4'b0000};

  always_comb begin
    load_data = word;
    case (a_size[1:0])
      2'b00:   load_data = {{24{byte_sh[7]  & ~a_size[2]}}, byte_sh[7:0]};
      2'b01:   load_data = {{16{half_sh[15] & ~a_size[2]}}, half_sh[15:0]};
      default: load_data = word;
    endcase
  end

  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    lane_data = a_wdata;
    case (a_size[1:0])
      2'b00: begin
        lane_mask = 32'h0000_00FF << {a_addr[1:0], 3'b000};
        lane_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = 32'h0000_FFFF << {a_addr[1], 4'b0000};
        lane_data = {2{a_wdata[15:0]}};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = a_wdata;
      end
    endcase
    store_word = (word & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      size_q    <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || a_we) ? 32'd0 : load_data;
        if (a_we && !err) mem[idx] <= store_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// tb_data_mem_lsu -- randomized and directed self-checking bench for data_mem_lsu against a byte-array model.
// Rev 1.0
module tb_data_mem_lsu;

  localparam int DEPTH       = 64;
  localparam int ADDR_W      = 32;
  localparam int WAIT_CYCLES = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [31:0]       rsp_rdata;

  int checks = 0;
  int fails  = 0;

  logic [7:0] ref_bytes [DEPTH*4];

  data_mem_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void clear_model();
    for (int i = 0; i < DEPTH*4; i++) ref_bytes[i] = 8'h00;
  endfunction

  // Byte-addressed reference: access width, legality, alignment and extension from the ISA rules.
  function automatic void model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int nbytes, ea;
    rd = 32'd0;
    er = 1'b0;
    case (sz)
      3'b000, 3'b100: nbytes = 1;
      3'b001, 3'b101: nbytes = 2;
      3'b010:         nbytes = 4;
      default:        nbytes = 0;
    endcase
    if (nbytes == 0 || a >= DEPTH*4 || (we && sz[2])) er = 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (!er && nbytes > 1 && (int'(a) % nbytes) != 0) er = 1'b1;
`endif
    if (er) return;
    ea = int'(a) - (int'(a) % nbytes);
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[ea+i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nbytes; i++) rd[8*i +: 8] = ref_bytes[ea+i];
      if (nbytes < 4 && !sz[2] && rd[8*nbytes-1]) rd = rd | (32'hFFFF_FFFF << (8*nbytes));
    end
  endfunction

  // Issues one request, scrambles the inputs after acceptance, and reports latency
  // counted from the accept cycle to the first cycle with rsp_valid.
  task automatic do_txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_size  = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'd0;
    req_addr  = '0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
      $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b, expected 0 0 0", rsp_valid, rsp_rdata, rsp_err);
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) fails++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got req_ready=%b, expected 1", req_ready);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    logic [2:0]  sz [6] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b100, 3'b010};
    logic        we [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad [6] = '{32'h44, 32'h44, 32'h45, 32'h45, 32'h45, 32'h44};
    logic [31:0] wd [6] = '{32'hDEAD_BEEF, 32'h0, 32'h0000_0080, 32'h0, 32'h0, 32'h0};
    logic [31:0] ex [6] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'hDEAD_80EF};
    for (int i = 0; i < 6; i++) begin
      do_txn(we[i], sz[i], ad[i], wd[i], 0, rd, er, lat);
      model(we[i], sz[i], ad[i], wd[i], erd, eer);
      checks++;
      if (rd !== ex[i] || er !== 1'b0 || lat !== WAIT_CYCLES + 1) begin
        fails++;
        $display("FAIL store_load[%0d]: got rdata=%h err=%b lat=%0d, expected rdata=%h err=0 lat=%0d",
                 i, rd, er, lat, ex[i], WAIT_CYCLES + 1);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    do_txn(1'b1, 3'b010, 32'h100, 32'h1234_5678, 0, rd, er, lat);
    model(1'b1, 3'b010, 32'h100, 32'h1234_5678, erd, eer);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      fails++;
      $display("FAIL err_out_of_range: got err=%b rdata=%h, expected err=1 rdata=0", er, rd);
    end
    do_txn(1'b0, 3'b010, 32'h0, 32'h0, 0, rd, er, lat);
    model(1'b0, 3'b010, 32'h0, 32'h0, erd, eer);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      fails++;
      $display("FAIL err_no_alias_write: got err=%b rdata=%h, expected err=0 rdata=0", er, rd);
    end
    do_txn(1'b0, 3'b011, 32'h44, 32'h0, 0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      fails++;
      $display("FAIL err_bad_size: got err=%b rdata=%h, expected err=1 rdata=0", er, rd);
    end
    do_txn(1'b1, 3'b100, 32'h44, 32'h0000_0011, 0, rd, er, lat);
    do_txn(1'b0, 3'b010, 32'h44, 32'h0, 0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_80EF || er !== 1'b0) begin
      fails++;
      $display("FAIL err_store_bu_no_write: got rdata=%h err=%b, expected rdata=dead80ef err=0", rd, er);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd0;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h44;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    rd0 = rsp_rdata;
    checks++;
    if (rsp_valid !== 1'b1 || rd0 !== 32'hDEAD_80EF) begin
      fails++;
      $display("FAIL bp_first_rsp: got valid=%b rdata=%h, expected valid=1 rdata=dead80ef", rsp_valid, rd0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b, expected 1 %h 0", i, rsp_valid, rsp_rdata, req_ready, rd0);
      end
    end
    req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_idle_gap: got valid=%b ready=%b, expected valid=0 ready=1", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_accept: got ready=%b, expected 0", req_ready);
    end
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || n !== WAIT_CYCLES + 1) begin
      fails++;
      $display("FAIL bp_second_rsp: got valid=%b rdata=%h err=%b lat=%0d, expected 1 0 0 %0d",
               rsp_valid, rsp_rdata, rsp_err, n, WAIT_CYCLES + 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midtxn;
    logic [31:0] rd;
    logic er;
    int lat;
    do_txn(1'b0, 3'b010, 32'h44, 32'h0, 0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h8; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_in_wait: got ready=%b, expected 0", req_ready);
    end
    rst_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_outputs: got valid=%b rdata=%h err=%b ready=%b, expected 0 0 0 1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 3'b010, 32'h8, 32'h0, 0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_no_commit: got rdata=%h err=%b, expected 0 0", rd, er);
    end
    do_txn(1'b0, 3'b010, 32'h44, 32'h0, 0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_array_cleared: got rdata=%h err=%b, expected 0 0", rd, er);
    end
  endtask

  task automatic test_halfword;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    do_txn(1'b1, 3'b001, 32'h2, 32'h0000_A5A5, 0, rd, er, lat);
    model(1'b1, 3'b001, 32'h2, 32'h0000_A5A5, erd, eer);
    do_txn(1'b0, 3'b001, 32'h2, 32'h0, 0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_A5A5 || er !== 1'b0) begin
      fails++;
      $display("FAIL half_lh: got rdata=%h err=%b, expected ffffa5a5 0", rd, er);
    end
    do_txn(1'b0, 3'b010, 32'h1, 32'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      fails++;
      $display("FAIL half_lw_misaligned: got rdata=%h err=%b, expected 0 1", rd, er);
    end
`else
    checks++;
    if (rd !== 32'hA5A5_0000 || er !== 1'b0) begin
      fails++;
      $display("FAIL half_lw_misaligned: got rdata=%h err=%b, expected a5a50000 0", rd, er);
    end
`endif
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, a, wd;
    logic er, eer, we;
    logic [2:0] sz;
    int lat;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 31));
      else a = 32'($urandom_range(0, DEPTH*4 - 1));
      wd = $urandom;
      do_txn(we, sz, a, wd, $urandom_range(0, 2), rd, er, lat);
      model(we, sz, a, wd, erd, eer);
      checks++;
      if (rd !== erd || er !== eer || lat !== WAIT_CYCLES + 1) begin
        fails++;
        $display("FAIL random[%0d] we=%b sz=%b a=%h wd=%h: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 i, we, sz, a, wd, rd, er, lat, erd, eer, WAIT_CYCLES + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_midtxn();
    test_halfword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words, power of two, minimum 4.
REQ-002 Parameter ADDR_W, default 32: width of the byte address.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0..15: extra cycles of access latency.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address, little-endian.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected.

Function
REQ-005 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-006 A request SHALL be accepted when req_valid && req_ready; addr, size, we and wdata SHALL be captured on that edge, and later input changes SHALL be ignored.
REQ-007 On accept, the FSM SHALL go IDLE->RESP if WAIT_CYCLES==0, else IDLE->WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-008 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP. rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-009 The array access (read sample or write commit) SHALL occur on the edge entering RESP; rsp_rdata/rsp_err SHALL be registered then and held stable while in RESP.
REQ-010 In RESP, the FSM SHALL go to IDLE on rsp_ready; if rsp_ready is 0, the response SHALL be held indefinitely. No new request SHALL be accepted in the same cycle as the RESP->IDLE transition.
REQ-011 Word index = req_addr[log2(DEPTH)+1:2]; if any req_addr bit above that field is nonzero, the access SHALL be out of range.
REQ-012 Loads: B/H SHALL sign-extend and BU/HU SHALL zero-extend the lane selected by addr[1:0] (byte) or addr[1] (half); W SHALL return the whole word.
REQ-013 Stores: B/H SHALL write only the addressed byte/halfword lane from req_wdata[7:0]/[15:0]; other lanes SHALL be preserved.
REQ-014 The following SHALL each give rsp_err=1, rsp_rdata=0 and no array write: out-of-range address, req_size 011/110/111, store with size BU or HU.
REQ-015 Read-after-write to the same address in consecutive transactions SHALL return the newly written data.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and all DEPTH words to 0.
REQ-017 Reset asserted mid-transaction SHALL abort it; a store not yet committed SHALL NOT modify the array.
REQ-018 After rst_n deasserts, req_ready SHALL be 1 on the first clock edge.

Configuration
REQ-019 With macro DMEM_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL set rsp_err=1 with no write and rsp_rdata=0.
REQ-020 Without DMEM_MISALIGN_CHECK_EN: misaligned accesses SHALL NOT set rsp_err; the offending low address bits SHALL be treated as 0 (natural alignment forced).

Verification
REQ-021 WAIT_CYCLES=1: SW 0xDEADBEEF to 0x44, then LW 0x44 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
REQ-022 After REQ-021: SB 0x80 to 0x45; LB 0x45 -> 0xFFFFFF80; LBU 0x45 -> 0x00000080; LW 0x44 -> 0xDEAD80EF.
REQ-023 DEPTH=64: SW to 0x100 -> rsp_err=1; LW 0x0 still 0; req_size 011 -> rsp_err=1.
REQ-024 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stable and req_ready=0 throughout; one idle cycle after rsp_ready before next accept.
REQ-025 Assert rst_n low during WAIT of SW 0x12345678 to 0x8 -> outputs 0 at once; LW 0x8 after reset -> 0x00000000.
REQ-026 LH 0x2 after SH 0xA5A5 to 0x2 -> 0xFFFFA5A5; LW 0x1 -> rsp_err=1 with DMEM_MISALIGN_CHECK_EN, else the word at 0x0.
